scs8hd_and3_filt: RTL and testbench
===================================

# scs8hd_and3_filt

Qualifying stage placed directly downstream of a 3-input AND gate cell. It takes the gate's output as an asynchronous level, synchronizes it into the `CLK` domain, and rejects pulses shorter than a programmable number of cycles. It publishes a debounced level with one-cycle rise and fall strobes and a saturating count of qualified rising events. Typical use: turning an AND-decoded condition from unclocked logic into a clean registered event source.

## Interface

**Parameters**
- `SYNC_STAGES`, default 2: synchronizer flop count. Legal values 2..4.
- `FILT_CYCLES`, default 4: consecutive synchronized cycles needed to accept a new level. Legal values 1..255.
- `CNT_W`, default 8: width of the event counter.

**Ports**
- `CLK`, input, 1: the single clock; all state updates on the rising edge.
- `RESETB`, input, 1: asynchronous, active-low reset.
- `D`, input, 1: raw level, normally the upstream AND output `X`. Asynchronous to `CLK`.
- `EN`, input, 1: filter enable.
- `CLR`, input, 1: synchronous clear of `EVCNT`.
- `Q`, output, 1: debounced level.
- `RISE`, output, 1: one-cycle strobe when `Q` goes 0→1.
- `FALL`, output, 1: one-cycle strobe when `Q` goes 1→0.
- `BUSY`, output, 1: high while a level change is being qualified.
- `EVCNT`, output, `CNT_W`: saturating count of `RISE` strobes.
- `vpwr`, `vgnd`, `vpb`, `vnb`, inputs, 1 each: present only when `SC_USE_PG_PIN` is defined; otherwise these are internal supplies.

## Operation

- **Reset.** `RESETB` low asynchronously sets:
  - sync chain = 0, state = `LOW`, counter = 0;
  - `Q`=0, `RISE`=0, `FALL`=0, `BUSY`=0, `EVCNT`=0.
- **Synchronizer.** `D` shifts through `SYNC_STAGES` flops. `s` denotes the last stage. The chain runs regardless of `EN`.
- **FSM states.** `LOW`, `QUAL_HI`, `HIGH`, `QUAL_LO`. `cnt` counts qualifying cycles and has ceil(log2(`FILT_CYCLES`+1)) bits.
- **`LOW`:**
  - if `EN` and `s`=1 and `FILT_CYCLES`=1, go to `HIGH`;
  - else if `EN` and `s`=1, go to `QUAL_HI` with `cnt`=1.
- **`QUAL_HI`:**
  - `s`=0: go to `LOW`, `cnt`=0;
  - `s`=1 and `cnt`=`FILT_CYCLES`-1: go to `HIGH`, `cnt`=0;
  - otherwise: `cnt`+1.
- **`HIGH` and `QUAL_LO`:** mirror images of `LOW` and `QUAL_HI`, with `s` inverted.
- **Outputs.**
  - `Q` is registered; it is 1 in `HIGH` and `QUAL_LO`.
  - `RISE` is registered and high for exactly the cycle after entry into `HIGH`. `FALL` behaves the same on entry into `LOW` from `QUAL_LO` or `HIGH`.
  - `BUSY` = state is `QUAL_HI` or `QUAL_LO`.
- **`EN`=0.**
  - A qualifying state returns to its stable state (`QUAL_HI`→`LOW`, `QUAL_LO`→`HIGH`) with `cnt`=0.
  - Stable states hold. `Q` holds. No strobes are generated.
- **`EVCNT`.**
  - Increments by 1 on each `RISE` and saturates at 2^`CNT_W`-1; it never wraps.
  - `CLR` sets it to 0 next edge and has priority: an increment in the same cycle is dropped.

## Timing

- Latency from the first edge sampling `D`=1 (`D` held steady):
  - `s`=1 after `SYNC_STAGES` edges;
  - `Q`=1 after `SYNC_STAGES`+`FILT_CYCLES` edges;
  - `RISE` is high during the cycle after that edge.
- Falling path latency is identical.
- A `D` pulse of fewer than `FILT_CYCLES` synchronized cycles produces no `Q` change. `BUSY` rises and falls with no strobe.
- `RISE` and `FALL` are never high in the same cycle. At least `FILT_CYCLES` cycles separate consecutive strobes.
- `RESETB` deassertion is not synchronized inside the block; it must meet recovery/removal timing at the boundary. Reset mid-qualification discards all progress.

## Structure

- Shared package `scs8hd_filt_pkg` holds:
  - the state encoding (2-bit: `LOW`=00, `QUAL_HI`=01, `HIGH`=11, `QUAL_LO`=10);
  - the function that computes `cnt` width from `FILT_CYCLES`.
- One sub-module, `scs8hd_sync_chain`: a parameterized N-flop synchronizer with asynchronous active-low reset to 0. It is reused by other clocked cells.
- The FSM, strobes and counter live in the top module.

## Test plan

Bench parameters: `SYNC_STAGES`=2, `FILT_CYCLES`=4 unless stated.

1. **Clean rise.** `D`=1 held 12 cycles with `EN`=1 → `Q`=1 after edge 6, `RISE` high one cycle, `EVCNT`=1, `BUSY` high for 3 cycles before `Q` rises.
2. **Glitch rejection.** `D`=1 for 3 cycles then 0 → `Q` stays 0, no `RISE`, `EVCNT`=0. Repeat for a falling glitch while `Q`=1 → `Q` stays 1.
3. **Saturation.** `CNT_W`=2 with 5 qualified pulses (each 8 high / 8 low) → `EVCNT` reads 1, 2, 3, 3, 3.
4. **Clear versus increment.** `CLR`=1 in the cycle `RISE` would increment, with `EVCNT`=2 → `EVCNT`=0 next cycle.
5. **Enable drop.** `EN`=0 at `cnt`=2 in `QUAL_HI` → state `LOW`, `BUSY`=0, `Q`=0. With `EN` back to 1 and `D` still high → `Q` rises 4 edges later.
6. **Reset mid-operation.** `RESETB` low asynchronously while in `QUAL_LO` with `EVCNT`=5 → all outputs 0 immediately, without waiting for a `CLK` edge. After release with `D`=1 → full `SYNC_STAGES`+`FILT_CYCLES` latency again.

Source files
------------

// File: rtl/scs8hd_filt_pkg.sv
// Shared types for the scs8hd qualifying filter cells:
// FSM state encoding and the qualify-counter width helper.
package scs8hd_filt_pkg;

  typedef enum logic [1:0] {
    ST_LOW     = 2'b00,
    ST_QUAL_HI = 2'b01,
    ST_HIGH    = 2'b11,
    ST_QUAL_LO = 2'b10
  } filt_state_e;

  // ceil(log2(cycles+1)), never below 1
  function automatic int filt_cnt_w(input int cycles);
    int w;
    w = 1;
    for (int i = 1; i < 17; i++) begin
      if ((1 << i) < (cycles + 1)) w = i + 1;
    end
    return w;
  endfunction

endpackage

// File: rtl/scs8hd_sync_chain.sv
// N-flop level synchronizer, async active-low reset to 0.
// Shared by the clocked scs8hd cells.
module scs8hd_sync_chain #(
  parameter int N = 2
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_d,
  output logic o_q
);

  logic [N-1:0] r_chain;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_chain <= '0;
    else          r_chain <= {r_chain[N-2:0], i_d};
  end

  assign o_q = r_chain[N-1];

endmodule

// File: rtl/scs8hd_and3_filt.sv
// Synchronizes and debounces an AND3 output level; emits
// rise/fall strobes and a saturating qualified-rise count.
module scs8hd_and3_filt
  import scs8hd_filt_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int FILT_CYCLES = 4,
  parameter int CNT_W       = 8
) (
`ifdef SC_USE_PG_PIN
  input  logic             vpwr,
  input  logic             vgnd,
  input  logic             vpb,
  input  logic             vnb,
`endif
  input  logic             CLK,
  input  logic             RESETB,
  input  logic             D,
  input  logic             EN,
  input  logic             CLR,
  output logic             Q,
  output logic             RISE,
  output logic             FALL,
  output logic             BUSY,
  output logic [CNT_W-1:0] EVCNT
);

`ifndef SC_USE_PG_PIN
  logic vpwr;
  logic vgnd;
  logic vpb;
  logic vnb;
  assign vpwr = 1'b1;
  assign vpb  = 1'b1;
  assign vgnd = 1'b0;
  assign vnb  = 1'b0;
`endif

  localparam int CW = filt_cnt_w(FILT_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(FILT_CYCLES - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  filt_state_e r_state;
  filt_state_e w_state_nxt;
  logic [CW-1:0] r_cnt;
  logic [CW-1:0] w_cnt_nxt;
  logic w_s;
  logic w_en;
  logic w_pwr_ok;
  logic w_q_nxt;
  logic w_rise_nxt;
  logic w_fall_nxt;
  logic r_q;
  logic r_rise;
  logic r_fall;
  logic [CNT_W-1:0] r_evcnt;

  // unpowered rails hold the filter disabled
  assign w_pwr_ok = vpwr & vpb & ~vgnd & ~vnb;
  assign w_en     = EN & w_pwr_ok;

  scs8hd_sync_chain #(
    .N (SYNC_STAGES)
  ) u_sync (
    .i_clk   (CLK),
    .i_rst_n (RESETB),
    .i_d     (D),
    .o_q     (w_s)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    unique case (r_state)
      ST_LOW: begin
        if (w_en && w_s) begin
          if (FILT_CYCLES == 1) begin
            w_state_nxt = ST_HIGH;
          end else begin
            w_state_nxt = ST_QUAL_HI;
            w_cnt_nxt   = CNT_ONE;
          end
        end
      end
      ST_QUAL_HI: begin
        if (!w_en || !w_s) begin
          w_state_nxt = ST_LOW;
          w_cnt_nxt   = '0;
        end else if (r_cnt == CNT_LAST) begin
          w_state_nxt = ST_HIGH;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt + CNT_ONE;
        end
      end
      ST_HIGH: begin
        if (w_en && !w_s) begin
          if (FILT_CYCLES == 1) begin
            w_state_nxt = ST_LOW;
          end else begin
            w_state_nxt = ST_QUAL_LO;
            w_cnt_nxt   = CNT_ONE;
          end
        end
      end
      ST_QUAL_LO: begin
        if (!w_en || w_s) begin
          w_state_nxt = ST_HIGH;
          w_cnt_nxt   = '0;
        end else if (r_cnt == CNT_LAST) begin
          w_state_nxt = ST_LOW;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt + CNT_ONE;
        end
      end
      default: begin
        w_state_nxt = ST_LOW;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  // aborted qualifications return to the stable state silently
  assign w_q_nxt    = (w_state_nxt == ST_HIGH) ||
                      (w_state_nxt == ST_QUAL_LO);
  assign w_rise_nxt = (w_state_nxt == ST_HIGH) &&
                      ((r_state == ST_LOW) ||
                       (r_state == ST_QUAL_HI));
  assign w_fall_nxt = (w_state_nxt == ST_LOW) &&
                      ((r_state == ST_HIGH) ||
                       (r_state == ST_QUAL_LO));

  always_ff @(posedge CLK or negedge RESETB) begin
    if (!RESETB) begin
      r_state <= ST_LOW;
      r_cnt   <= '0;
      r_q     <= 1'b0;
      r_rise  <= 1'b0;
      r_fall  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_q     <= w_q_nxt;
      r_rise  <= w_rise_nxt;
      r_fall  <= w_fall_nxt;
    end
  end

  always_ff @(posedge CLK or negedge RESETB) begin
    if (!RESETB) begin
      r_evcnt <= '0;
    end else if (CLR) begin
      r_evcnt <= '0;
    end else if (r_rise && (r_evcnt != {CNT_W{1'b1}})) begin
      r_evcnt <= r_evcnt + CNT_W'(1);
    end
  end

  assign Q     = r_q;
  assign RISE  = r_rise;
  assign FALL  = r_fall;
  assign BUSY  = (r_state == ST_QUAL_HI) ||
                 (r_state == ST_QUAL_LO);
  assign EVCNT = r_evcnt;

endmodule

// File: tb/tb_scs8hd_and3_filt.sv
// Scoreboard bench for scs8hd_and3_filt: strobe timing,
// glitch rejection, enable drop, clear, saturation, reset.
module tb_scs8hd_and3_filt;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       d;
  logic       en;
  logic       clr;
  logic       q;
  logic       rise;
  logic       fall;
  logic       busy;
  logic [7:0] evcnt;

  logic       rst2_n;
  logic       d2;
  logic       q2;
  logic       rise2;
  logic       fall2;
  logic       busy2;
  logic [1:0] evcnt2;

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;

  typedef struct {
    bit is_rise;
    int at;
  } ev_t;

  ev_t exp_q[$];
  int  sat_q[$];
  bit  sat_seen = 1'b0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  scs8hd_and3_filt #(
    .SYNC_STAGES (2),
    .FILT_CYCLES (4),
    .CNT_W       (8)
  ) u_dut (
    .CLK    (clk),
    .RESETB (rst_n),
    .D      (d),
    .EN     (en),
    .CLR    (clr),
    .Q      (q),
    .RISE   (rise),
    .FALL   (fall),
    .BUSY   (busy),
    .EVCNT  (evcnt)
  );

  scs8hd_and3_filt #(
    .SYNC_STAGES (2),
    .FILT_CYCLES (4),
    .CNT_W       (2)
  ) u_sat (
    .CLK    (clk),
    .RESETB (rst2_n),
    .D      (d2),
    .EN     (1'b1),
    .CLR    (1'b0),
    .Q      (q2),
    .RISE   (rise2),
    .FALL   (fall2),
    .BUSY   (busy2),
    .EVCNT  (evcnt2)
  );

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cyc %0d)",
               tag, got, exp, cyc);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic push_ev(input bit r, input int dly);
    ev_t e;
    e.is_rise = r;
    e.at      = cyc + dly;
    exp_q.push_back(e);
  endtask

  // strobe monitor for the main instance
  always @(negedge clk) begin
    if (rst_n && (rise || fall)) begin
      check("strobe_excl", 32'(rise & fall), 0);
      if (exp_q.size() == 0) begin
        check("strobe_unexpected", 1, 0);
      end else begin
        ev_t e;
        e = exp_q.pop_front();
        check("strobe_kind", 32'(rise), 32'(e.is_rise));
        check("strobe_cyc", cyc, e.at);
      end
    end
  end

  // saturation monitor: count settles one edge after RISE
  always @(negedge clk) begin
    if (sat_seen) begin
      if (sat_q.size() == 0) begin
        check("sat_unexpected", 1, 0);
      end else begin
        check("sat_evcnt", 32'(evcnt2), sat_q.pop_front());
      end
    end
    sat_seen <= rst2_n & rise2;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    rst_n  = 1'b0;
    rst2_n = 1'b0;
    d      = 1'b0;
    d2     = 1'b0;
    en     = 1'b0;
    clr    = 1'b0;
    tick(3);
    check("rst_q", 32'(q), 0);
    check("rst_rise", 32'(rise), 0);
    check("rst_fall", 32'(fall), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_evcnt", 32'(evcnt), 0);
    rst_n  = 1'b1;
    rst2_n = 1'b1;
    en     = 1'b1;
    tick(2);

    // clean rise
    d = 1'b1;
    push_ev(1'b1, 6);
    tick(2);
    check("t1_busy_e2", 32'(busy), 0);
    tick(1);
    check("t1_busy_e3", 32'(busy), 1);
    tick(2);
    check("t1_busy_e5", 32'(busy), 1);
    check("t1_q_e5", 32'(q), 0);
    tick(1);
    check("t1_q_e6", 32'(q), 1);
    check("t1_busy_e6", 32'(busy), 0);
    tick(1);
    check("t1_rise_e7", 32'(rise), 0);
    check("t1_evcnt", 32'(evcnt), 1);
    tick(5);

    // falling glitch while high
    d = 1'b0;
    tick(3);
    d = 1'b1;
    check("t2_busy_lo", 32'(busy), 1);
    check("t2_q_hold", 32'(q), 1);
    tick(6);
    check("t2_q_hi", 32'(q), 1);
    check("t2_busy_idle", 32'(busy), 0);

    d = 1'b0;
    push_ev(1'b0, 6);
    tick(8);
    check("t2_q_lo", 32'(q), 0);

    // rising glitch while low
    d = 1'b1;
    tick(3);
    d = 1'b0;
    tick(8);
    check("t2_q_stay", 32'(q), 0);
    check("t2_evcnt", 32'(evcnt), 1);

    // clear wins over a coincident increment
    d = 1'b1;
    push_ev(1'b1, 6);
    tick(8);
    d = 1'b0;
    push_ev(1'b0, 6);
    tick(8);
    d = 1'b1;
    push_ev(1'b1, 6);
    tick(6);
    check("t4_rise", 32'(rise), 1);
    check("t4_evcnt_pre", 32'(evcnt), 2);
    clr = 1'b1;
    tick(1);
    clr = 1'b0;
    check("t4_evcnt_clr", 32'(evcnt), 0);
    tick(1);
    check("t4_evcnt_hold", 32'(evcnt), 0);
    d = 1'b0;
    push_ev(1'b0, 6);
    tick(8);

    // enable drop during qualification
    d = 1'b1;
    tick(4);
    check("t5_busy_cnt2", 32'(busy), 1);
    en = 1'b0;
    tick(1);
    check("t5_busy_drop", 32'(busy), 0);
    check("t5_q_drop", 32'(q), 0);
    tick(2);
    check("t5_q_hold", 32'(q), 0);
    en = 1'b1;
    push_ev(1'b1, 4);
    tick(3);
    check("t5_q_e3", 32'(q), 0);
    check("t5_busy_e3", 32'(busy), 1);
    tick(1);
    check("t5_q_e4", 32'(q), 1);
    tick(2);

    // build EVCNT up to 5
    for (int k = 0; k < 4; k++) begin
      d = 1'b0;
      push_ev(1'b0, 6);
      tick(8);
      d = 1'b1;
      push_ev(1'b1, 6);
      tick(8);
    end
    check("t6_evcnt5", 32'(evcnt), 5);

    // async reset mid QUAL_LO
    d = 1'b0;
    tick(3);
    check("t6_busy", 32'(busy), 1);
    check("t6_q", 32'(q), 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("t6_rst_q", 32'(q), 0);
    check("t6_rst_busy", 32'(busy), 0);
    check("t6_rst_evcnt", 32'(evcnt), 0);
    check("t6_rst_rise", 32'(rise), 0);
    check("t6_rst_fall", 32'(fall), 0);
    tick(2);
    rst_n = 1'b1;
    d     = 1'b1;
    push_ev(1'b1, 6);
    tick(5);
    check("t6_q_e5", 32'(q), 0);
    tick(1);
    check("t6_q_e6", 32'(q), 1);
    tick(1);
    check("t6_evcnt_new", 32'(evcnt), 1);

    // saturation on the 2-bit counter instance
    for (int k = 1; k <= 5; k++) begin
      d2 = 1'b1;
      sat_q.push_back((k > 3) ? 3 : k);
      tick(8);
      d2 = 1'b0;
      tick(8);
    end

    check("sb_empty", exp_q.size(), 0);
    check("sat_sb_empty", sat_q.size(), 0);
    check("sat_final", 32'(evcnt2), 3);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
